// File: rtl/lock_ctrl_pkg.sv
// Shared types for the locked register arbiter: FSM states, operation encoding
// and an index-width helper.
package lock_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMMIT  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_LOCK  = 1'b1
    } op_t;

    // Width of an index into n items, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first asserted request at or after ptr, wrapping.
module rr_arbiter
    import lock_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PTR_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_c,
    output logic [PTR_W-1:0]   gnt_idx_c,
    output logic               any_c
);

    logic [PTR_W-1:0] cand;

    // Scan requesters starting at ptr; the first one found wins.
    always_comb begin
        gnt_c     = '0;
        gnt_idx_c = '0;
        any_c     = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((32'(ptr) + k) % NUM_REQ);
            if (!any_c && req[cand]) begin
                any_c       = 1'b1;
                gnt_c[cand] = 1'b1;
                gnt_idx_c   = cand;
            end
        end
    end

endmodule

// File: rtl/locked_reg_arbiter.sv
// Arbitrated register file with per-register write locks.
// Requesters are served one transaction at a time in round-robin order; a lock
// operation write-protects a register until reset.
// Optional feature macro DEBUG_UNLOCK_EN: when defined, debug_unlocked=1 in
// COMMIT lets writes pass locked registers; otherwise debug_unlocked is ignored.
module locked_reg_arbiter
    import lock_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned DATA_W   = 16
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           op_lock,
    input  logic [NUM_REQ*idx_w(NUM_REGS)-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0]    Data_in,
    input  logic                         debug_unlocked,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           ack,
    output logic [NUM_REQ-1:0]           err,
    output logic [NUM_REGS*DATA_W-1:0]   Data_out,
    output logic [NUM_REGS-1:0]          lock_status
);

    localparam int unsigned ADDR_W = idx_w(NUM_REGS);
    localparam int unsigned PTR_W  = idx_w(NUM_REQ);

    state_t              state;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    lat_idx;
    op_t                 lat_op;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_data;

    logic [NUM_REQ-1:0]  sel_gnt_c;
    logic [PTR_W-1:0]    sel_idx_c;
    logic                sel_any_c;
    logic                override_c;

`ifdef DEBUG_UNLOCK_EN
    assign override_c = debug_unlocked;
`else
    logic unused_debug;
    assign unused_debug = debug_unlocked;
    assign override_c   = 1'b0;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req       (req),
        .ptr       (rr_ptr),
        .gnt_c     (sel_gnt_c),
        .gnt_idx_c (sel_idx_c),
        .any_c     (sel_any_c)
    );

    // Transaction FSM: latch in IDLE, execute in COMMIT, hold grant in RELEASE.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            lat_idx     <= '0;
            lat_op      <= OP_WRITE;
            lat_addr    <= '0;
            lat_data    <= '0;
            gnt         <= '0;
            ack         <= '0;
            err         <= '0;
            Data_out    <= '0;
            lock_status <= '0;
        end else begin
            ack <= '0;
            err <= '0;
            case (state)
                IDLE: begin
                    if (sel_any_c) begin
                        lat_idx  <= sel_idx_c;
                        lat_op   <= op_t'(op_lock[sel_idx_c]);
                        lat_addr <= addr[32'(sel_idx_c)*ADDR_W +: ADDR_W];
                        lat_data <= Data_in[32'(sel_idx_c)*DATA_W +: DATA_W];
                        gnt      <= sel_gnt_c;
                        state    <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (lat_op == OP_LOCK) begin
                        lock_status[lat_addr] <= 1'b1;
                        ack[lat_idx]          <= 1'b1;
                    end else if (!lock_status[lat_addr] || override_c) begin
                        Data_out[32'(lat_addr)*DATA_W +: DATA_W] <= lat_data;
                        ack[lat_idx] <= 1'b1;
                    end else begin
                        err[lat_idx] <= 1'b1;
                    end
                    state <= RELEASE;
                end
                RELEASE: begin
                    if (!req[lat_idx]) begin
                        gnt    <= '0;
                        rr_ptr <= (lat_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                                   : lat_idx + PTR_W'(1);
                        state  <= IDLE;
                    end
                end
                default: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_locked_reg_arbiter.sv
// Directed self-checking bench for locked_reg_arbiter (2 requesters, 4 x 16-bit).
module tb_locked_reg_arbiter;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [1:0]  req;
    logic [1:0]  op_lock;
    logic [3:0]  addr;
    logic [31:0] Data_in;
    logic        debug_unlocked;
    logic [1:0]  gnt;
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [63:0] Data_out;
    logic [3:0]  lock_status;

    int n_cmp = 0;
    int n_bad = 0;

    locked_reg_arbiter dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .req            (req),
        .op_lock        (op_lock),
        .addr           (addr),
        .Data_in        (Data_in),
        .debug_unlocked (debug_unlocked),
        .gnt            (gnt),
        .ack            (ack),
        .err            (err),
        .Data_out       (Data_out),
        .lock_status    (lock_status)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] word(input int i);
        return Data_out[i*16 +: 16];
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic op, input int a, input logic [15:0] d);
        op_lock[idx]         = op;
        addr[idx*2 +: 2]     = 2'(a);
        Data_in[idx*16 +: 16] = d;
        req[idx]             = 1'b1;
    endtask

    // Drives one transaction; reports what came back and the ack/err latency
    // (-1 if ack/err or the grant release never arrived).
    task automatic run_txn(input int idx, input logic op, input int a, input logic [15:0] d,
                           output logic [1:0] ack_seen, output logic [1:0] err_seen,
                           output int lat);
        bit done;
        done     = 1'b0;
        ack_seen = '0;
        err_seen = '0;
        lat      = -1;
        set_req(idx, op, a, d);
        for (int c = 1; c <= 8 && !done; c++) begin
            tick();
            if ((ack | err) != 2'b00) begin
                ack_seen = ack;
                err_seen = err;
                lat      = c;
                done     = 1'b1;
            end
        end
        req[idx] = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 8 && !done; c++) begin
            tick();
            if (gnt == 2'b00) done = 1'b1;
        end
        if (!done) lat = -1;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        req = '0;
        tick();
        tick();
        Rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL reset_gnt: got %b want 00", gnt); end
        n_cmp++; if (ack !== 2'b00) begin n_bad++; $display("FAIL reset_ack: got %b want 00", ack); end
        n_cmp++; if (err !== 2'b00) begin n_bad++; $display("FAIL reset_err: got %b want 00", err); end
        n_cmp++; if (Data_out !== 64'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", Data_out); end
        n_cmp++; if (lock_status !== 4'b0000) begin n_bad++; $display("FAIL reset_lock: got %b want 0000", lock_status); end
    endtask

    task automatic test_write();
        logic [1:0] a, e;
        int lat;
        run_txn(0, 1'b0, 1, 16'hA5A5, a, e, lat);
        n_cmp++; if (a !== 2'b01) begin n_bad++; $display("FAIL write_ack: got %b want 01", a); end
        n_cmp++; if (e !== 2'b00) begin n_bad++; $display("FAIL write_err: got %b want 00", e); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL write_latency: got %0d want 2", lat); end
        n_cmp++; if (word(1) !== 16'hA5A5) begin n_bad++; $display("FAIL write_data1: got %h want a5a5", word(1)); end
    endtask

    task automatic test_lock();
        logic [1:0] a, e;
        int lat;
        run_txn(0, 1'b1, 1, 16'h0000, a, e, lat);
        n_cmp++; if (a !== 2'b01) begin n_bad++; $display("FAIL lock_ack: got %b want 01", a); end
        n_cmp++; if (lock_status !== 4'b0010) begin n_bad++; $display("FAIL lock_status: got %b want 0010", lock_status); end
        run_txn(1, 1'b0, 1, 16'h1234, a, e, lat);
        n_cmp++; if (e !== 2'b10) begin n_bad++; $display("FAIL locked_err: got %b want 10", e); end
        n_cmp++; if (a !== 2'b00) begin n_bad++; $display("FAIL locked_ack: got %b want 00", a); end
        n_cmp++; if (word(1) !== 16'hA5A5) begin n_bad++; $display("FAIL locked_data1: got %h want a5a5", word(1)); end
        run_txn(1, 1'b1, 1, 16'h0000, a, e, lat);
        n_cmp++; if (a !== 2'b10) begin n_bad++; $display("FAIL relock_ack: got %b want 10", a); end
        n_cmp++; if (lock_status !== 4'b0010) begin n_bad++; $display("FAIL relock_status: got %b want 0010", lock_status); end
    endtask

    task automatic test_round_robin();
        logic [1:0] a, e;
        int lat;
        // Pointer is 0 here: requester 0 goes first.
        set_req(0, 1'b0, 0, 16'h1111);
        set_req(1, 1'b0, 2, 16'h2222);
        tick();
        n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL rr0_first_gnt: got %b want 01", gnt); end
        tick();
        n_cmp++; if (ack !== 2'b01) begin n_bad++; $display("FAIL rr0_first_ack: got %b want 01", ack); end
        req[0] = 1'b0;
        tick();
        n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL rr0_gap_gnt: got %b want 00", gnt); end
        tick();
        n_cmp++; if (gnt !== 2'b10) begin n_bad++; $display("FAIL rr0_second_gnt: got %b want 10", gnt); end
        tick();
        n_cmp++; if (ack !== 2'b10) begin n_bad++; $display("FAIL rr0_second_ack: got %b want 10", ack); end
        req[1] = 1'b0;
        tick();
        n_cmp++; if (word(0) !== 16'h1111 || word(2) !== 16'h2222) begin
            n_bad++; $display("FAIL rr0_data: got %h/%h want 1111/2222", word(0), word(2)); end
        // Move the pointer to 1 and raise both again: requester 1 first.
        run_txn(0, 1'b0, 0, 16'h3333, a, e, lat);
        set_req(0, 1'b0, 3, 16'h4444);
        set_req(1, 1'b0, 3, 16'h5555);
        tick();
        n_cmp++; if (gnt !== 2'b10) begin n_bad++; $display("FAIL rr1_first_gnt: got %b want 10", gnt); end
        tick();
        n_cmp++; if (ack !== 2'b10) begin n_bad++; $display("FAIL rr1_first_ack: got %b want 10", ack); end
        req[1] = 1'b0;
        tick();
        tick();
        n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL rr1_second_gnt: got %b want 01", gnt); end
        tick();
        n_cmp++; if (ack !== 2'b01) begin n_bad++; $display("FAIL rr1_second_ack: got %b want 01", ack); end
        req[0] = 1'b0;
        tick();
        n_cmp++; if (word(3) !== 16'h4444) begin n_bad++; $display("FAIL rr1_data3: got %h want 4444", word(3)); end
    endtask

    task automatic test_debug_unlock();
        logic [1:0] a, e;
        int lat;
        logic [1:0]  exp_ack, exp_err;
        logic [15:0] exp_w2;
`ifdef DEBUG_UNLOCK_EN
        exp_ack = 2'b01; exp_err = 2'b00; exp_w2 = 16'hBEEF;
`else
        exp_ack = 2'b00; exp_err = 2'b01; exp_w2 = 16'h2222;
`endif
        run_txn(1, 1'b1, 2, 16'h0000, a, e, lat);
        n_cmp++; if (lock_status !== 4'b0110) begin n_bad++; $display("FAIL dbg_lock: got %b want 0110", lock_status); end
        debug_unlocked = 1'b1;
        run_txn(0, 1'b0, 2, 16'hBEEF, a, e, lat);
        debug_unlocked = 1'b0;
        n_cmp++; if (a !== exp_ack) begin n_bad++; $display("FAIL dbg_ack: got %b want %b", a, exp_ack); end
        n_cmp++; if (e !== exp_err) begin n_bad++; $display("FAIL dbg_err: got %b want %b", e, exp_err); end
        n_cmp++; if (word(2) !== exp_w2) begin n_bad++; $display("FAIL dbg_data2: got %h want %h", word(2), exp_w2); end
        run_txn(1, 1'b0, 2, 16'hCAFE, a, e, lat);
        n_cmp++; if (e !== 2'b10) begin n_bad++; $display("FAIL nodbg_err: got %b want 10", e); end
        n_cmp++; if (word(2) !== exp_w2) begin n_bad++; $display("FAIL nodbg_data2: got %h want %h", word(2), exp_w2); end
    endtask

    task automatic test_reset_in_commit();
        logic [1:0] a, e;
        int lat;
        do_reset();
        set_req(0, 1'b0, 3, 16'h7777);
        tick();
        n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL rstc_gnt_before: got %b want 01", gnt); end
        Rst = 1'b1;
        req = '0;
        tick();
        n_cmp++; if ((ack | err) !== 2'b00) begin n_bad++; $display("FAIL rstc_ackerr: got %b want 00", ack | err); end
        n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL rstc_gnt: got %b want 00", gnt); end
        n_cmp++; if (word(3) !== 16'h0000) begin n_bad++; $display("FAIL rstc_data3: got %h want 0000", word(3)); end
        n_cmp++; if (lock_status !== 4'b0000) begin n_bad++; $display("FAIL rstc_lock: got %b want 0000", lock_status); end
        Rst = 1'b0;
        run_txn(1, 1'b0, 0, 16'h0101, a, e, lat);
        n_cmp++; if (lat !== 2 || a !== 2'b10) begin n_bad++; $display("FAIL rstc_idle_txn: got lat %0d ack %b want 2/10", lat, a); end
        n_cmp++; if (word(0) !== 16'h0101) begin n_bad++; $display("FAIL rstc_data0: got %h want 0101", word(0)); end
    endtask

    task automatic test_hold();
        set_req(0, 1'b0, 0, 16'h0A0A);
        tick();
        tick();
        n_cmp++; if (ack !== 2'b01) begin n_bad++; $display("FAIL hold_ack0: got %b want 01", ack); end
        set_req(1, 1'b0, 1, 16'h0B0B);
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (gnt !== 2'b01 || (ack | err) !== 2'b00) begin
                n_bad++; $display("FAIL hold_cycle%0d: got gnt %b ackerr %b want 01/00", c, gnt, ack | err); end
        end
        req[0] = 1'b0;
        tick();
        n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL hold_release: got %b want 00", gnt); end
        tick();
        n_cmp++; if (gnt !== 2'b10) begin n_bad++; $display("FAIL hold_next_gnt: got %b want 10", gnt); end
        tick();
        n_cmp++; if (ack !== 2'b10) begin n_bad++; $display("FAIL hold_next_ack: got %b want 10", ack); end
        req[1] = 1'b0;
        tick();
        n_cmp++; if (word(0) !== 16'h0A0A || word(1) !== 16'h0B0B) begin
            n_bad++; $display("FAIL hold_data: got %h/%h want 0a0a/0b0b", word(0), word(1)); end
    endtask

    task automatic test_drop_early();
        set_req(0, 1'b0, 3, 16'h9999);
        tick();
        req[0] = 1'b0;
        tick();
        n_cmp++; if (ack !== 2'b01) begin n_bad++; $display("FAIL drop_ack: got %b want 01", ack); end
        n_cmp++; if (word(3) !== 16'h9999) begin n_bad++; $display("FAIL drop_data3: got %h want 9999", word(3)); end
        tick();
        n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL drop_gnt: got %b want 00", gnt); end
    endtask

    initial begin
        Rst            = 1'b1;
        req            = '0;
        op_lock        = '0;
        addr           = '0;
        Data_in        = '0;
        debug_unlocked = 1'b0;
        test_reset();
        test_write();
        test_lock();
        test_round_robin();
        test_debug_unlock();
        test_reset_in_commit();
        test_hold();
        test_drop_early();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
